pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator. Measures an incoming PWM

---
 rtl/pwm_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 33 +++
 rtl/pwm_capture.sv | 120 ++++++++++++
 tb/tb_pwm_capture.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: default counter width
// and the capture FSM state encoding.
package pwm_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef logic [1:0] cap_state_t;

    localparam cap_state_t ST_SEEK = 2'd0;
    localparam cap_state_t ST_HIGH = 2'd1;
    localparam cap_state_t ST_LOW  = 2'd2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain plus one history flop; flags single-cycle rise/fall
// pulses of an asynchronous input with a fixed latency.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~hist_q;
    assign fall = ~q & hist_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in
// clk cycles; publishes each complete period with a one-cycle valid strobe.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic rise, fall, pwm_sync_unused;

    cap_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stalled_q, stalled_d;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (pwm_in),
        .rise (rise),
        .fall (fall),
        .q    (pwm_sync_unused)
    );

    // NOTE: every next-state signal is given a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_lat_d  = hi_lat_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;

        unique case (state_q)
            ST_SEEK: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt_q == CNT_MAX) begin
                    stalled_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_SEEK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (fall) begin
                        hi_lat_d = cnt_q;
                        state_d  = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                // Saturation wins over a coincident rise so the counter never wraps.
                if (cnt_q == CNT_MAX) begin
                    stalled_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_SEEK;
                end else if (rise) begin
                    period_d  = cnt_q;
                    high_d    = hi_lat_q;
                    valid_d   = 1'b1;
                    stalled_d = 1'b0;
                    cnt_d     = CNT_ONE;
                    state_d   = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SEEK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_SEEK;
            cnt_q     <= '0;
            hi_lat_q  <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_lat_q  <= hi_lat_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign meas_valid = valid_q;
    assign stalled    = stalled_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: one 16-bit and one 8-bit instance see the
// same pin; a pin-level reference model predicts every valid and stall event.
module tb_pwm_capture;

    localparam int L = 2;  // pin sample -> output visible, in cycles

    typedef struct {
        bit     is_stall;
        longint cyc;
        int     hi;
        int     per;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        pwm_in;
    logic [15:0] hi16, per16;
    logic [7:0]  hi8, per8;
    logic        v16, v8, s16, s8;

    longint cyc;
    int     checks;
    int     failures;

    ev_t q16[$];
    ev_t q8[$];

    // reference model state, lane 0 = 16-bit instance, lane 1 = 8-bit instance
    bit     prev;
    bit     armed [2];
    longint rise_k[2];
    longint fall_k[2];
    int     mhi   [2];
    int     mper  [2];
    longint maxc  [2];

    // monitor state
    int mon_hi [2];
    int mon_per[2];
    bit s_prev [2];

    pwm_capture u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .high_cnt   (hi16),
        .period_cnt (per16),
        .meas_valid (v16),
        .stalled    (s16)
    );

    pwm_capture #(.CNT_W(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .high_cnt   (hi8),
        .period_cnt (per8),
        .meas_valid (v8),
        .stalled    (s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int i, input ev_t e);
        if (i == 0) q16.push_back(e);
        else        q8.push_back(e);
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q16.size() : q8.size();
    endfunction

    function automatic ev_t qhead(input int i);
        return (i == 0) ? q16[0] : q8[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q16.pop_front());
        else        void'(q8.pop_front());
    endtask

    // Pin-level model: value v is sampled by the posedge numbered k.
    task automatic model_step(input longint k, input bit v);
        bit r, f, stall_now;
        ev_t e;
        r = v && !prev;
        f = !v && prev;
        for (int i = 0; i < 2; i++) begin
            stall_now = 1'b0;
            if (armed[i] && (k - rise_k[i]) == maxc[i]) begin
                e = '{1'b1, k + L, mhi[i], mper[i]};
                push(i, e);
                armed[i] = 1'b0;
                stall_now = 1'b1;
            end
            if (f) fall_k[i] = k;
            if (r && !stall_now) begin
                if (armed[i]) begin
                    mhi[i]  = int'(fall_k[i] - rise_k[i]);
                    mper[i] = int'(k - rise_k[i]);
                    e = '{1'b0, k + L, mhi[i], mper[i]};
                    push(i, e);
                end
                armed[i]  = 1'b1;
                rise_k[i] = k;
            end
        end
        prev = v;
    endtask

    task automatic model_reset();
        prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            armed[i] = 1'b0;
            mhi[i]   = 0;
            mper[i]  = 0;
        end
    endtask

    // Called and returns at a negedge; drives one pin value per cycle.
    task automatic drive(input bit v, input int n);
        for (int j = 0; j < n; j++) begin
            pwm_in = v;
            model_step(cyc + 1, v);
            @(negedge clk);
        end
    endtask

    task automatic pwm_periods(input int hi, input int lo, input int n);
        for (int j = 0; j < n; j++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    // Asserts reset off the clock edge, checks outputs clear at once, releases at a negedge.
    task automatic do_reset(input bit pin_at_release);
        #3 rst = 1'b0;
        #1;
        check("rst_high16", hi16, 0);
        check("rst_per16",  per16, 0);
        check("rst_valid16", v16, 0);
        check("rst_stall16", s16, 0);
        check("rst_high8",  hi8, 0);
        check("rst_per8",   per8, 0);
        check("rst_valid8", v8, 0);
        check("rst_stall8", s8, 0);
        q16.delete();
        q8.delete();
        for (int i = 0; i < 2; i++) begin
            mon_hi[i]  = 0;
            mon_per[i] = 0;
        end
        pwm_in = pin_at_release;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic lane(input int i, input bit v, input bit s, input int hi, input int per);
        ev_t e;
        if (v || (s && !s_prev[i])) begin
            if (qsize(i) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event lane%0d: got valid=%0d stalled=%0d expected none (cycle %0d)",
                         i, v, s, cyc);
            end else begin
                e = qhead(i);
                qpop(i);
                check($sformatf("kind%0d", i), !v, e.is_stall);
                check($sformatf("event_cycle%0d", i), cyc, e.cyc);
                check($sformatf("high_cnt%0d", i), hi, e.hi);
                check($sformatf("period_cnt%0d", i), per, e.per);
                if (v) check($sformatf("stall_clear%0d", i), s, 0);
                mon_hi[i]  = e.hi;
                mon_per[i] = e.per;
            end
        end else if (qsize(i) != 0 && qhead(i).cyc < cyc) begin
            e = qhead(i);
            qpop(i);
            checks++;
            failures++;
            $display("FAIL missed_event lane%0d: got nothing expected %s at cycle %0d (now %0d)",
                     i, e.is_stall ? "stall" : "valid", e.cyc, cyc);
        end else begin
            check($sformatf("hold_high%0d", i), hi, mon_hi[i]);
            check($sformatf("hold_period%0d", i), per, mon_per[i]);
        end
        s_prev[i] = s;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            lane(0, v16, s16, int'(hi16), int'(per16));
            lane(1, v8,  s8,  int'(hi8),  int'(per8));
        end else begin
            s_prev[0] = 1'b0;
            s_prev[1] = 1'b0;
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        maxc[0]  = 65535;
        maxc[1]  = 255;
        for (int i = 0; i < 2; i++) begin
            mon_hi[i]  = 0;
            mon_per[i] = 0;
            s_prev[i]  = 1'b0;
        end
        model_reset();
        rst    = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("init_high16", hi16, 0);
        check("init_valid16", v16, 0);
        check("init_stall8", s8, 0);
        check("init_period8", per8, 0);
        rst = 1'b1;

        // steady 3 high / 5 low
        pwm_periods(3, 5, 6);
        drive(1'b0, 4);

        // pin high at reset release, then 2 high / 6 low
        do_reset(1'b1);
        drive(1'b1, 4);
        drive(1'b0, 6);
        pwm_periods(2, 6, 5);

        // minimum high time: 1 high / 9 low
        pwm_periods(1, 9, 6);

        // randomized duty and period
        for (int j = 0; j < 40; j++)
            pwm_periods($urandom_range(40, 1), $urandom_range(40, 1), 1);

        // 8-bit boundary: period 254 accepted, period 255 stalls
        pwm_periods(10, 244, 1);
        pwm_periods(10, 245, 1);
        pwm_periods(3, 5, 3);

        // input stuck low, then recovery
        drive(1'b0, 300);
        pwm_periods(3, 5, 3);

        // input stuck high, then recovery
        drive(1'b1, 300);
        drive(1'b0, 5);
        pwm_periods(3, 5, 3);

        // reset in the middle of a low phase
        pwm_periods(3, 5, 3);
        drive(1'b1, 3);
        drive(1'b0, 2);
        do_reset(1'b0);
        drive(1'b0, 2);
        pwm_periods(4, 4, 4);

        // 16-bit stall on a dead input
        pwm_periods(3, 5, 1);
        drive(1'b0, 65540);
        pwm_periods(3, 5, 3);
        drive(1'b0, 10);

        check("sb_empty16", q16.size(), 0);
        check("sb_empty8",  q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
